// File: rtl/sop_pos_sweep_checker.sv
// Exhaustive truth-table sweeper that compares the SOP (minterm) and POS (maxterm) forms of one function.
// Optional build macro: SWEEP_STOP_ON_MISMATCH_EN ends the sweep at the first mismatching vector.
module sop_pos_sweep_checker #(
  parameter int unsigned N    = 3,
  parameter int unsigned HOLD = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2**N-1:0]   sop_mask,
  input  logic [2**N-1:0]   pos_mask,
  output logic              busy,
  output logic              vec_valid,
  output logic [N-1:0]      vec,
  output logic              f_sop,
  output logic              f_pos,
  output logic              done,
  output logic [N:0]        ones_cnt,
  output logic [N:0]        mismatch_cnt,
  output logic              mm_found,
  output logic [N-1:0]      first_mm_idx,
  output logic              equiv
);

  localparam int unsigned NV = 2**N;
  localparam int unsigned CW = N + 1;
  localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [N-1:0]  VMAX  = N'(NV - 1);
  localparam logic [HW-1:0] HLAST = HW'(HOLD - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state, state_d;
  logic [N-1:0]    vec_d;
  logic [HW-1:0]   hold_cnt, hold_d;
  logic [NV-1:0]   sop_q, sop_d, pos_q, pos_d;
  logic [CW-1:0]   ones_d, mm_d;
  logic            found_d;
  logic [N-1:0]    idx_d;
  logic            mm_c;
  logic            last_c;

  // Next-state and next-result computation
  always_comb begin
    state_d = state;
    vec_d   = vec;
    hold_d  = hold_cnt;
    sop_d   = sop_q;
    pos_d   = pos_q;
    ones_d  = ones_cnt;
    mm_d    = mismatch_cnt;
    found_d = mm_found;
    idx_d   = first_mm_idx;
    mm_c    = (f_sop != f_pos);
`ifdef SWEEP_STOP_ON_MISMATCH_EN
    last_c  = (vec == VMAX) || mm_c;
`else
    last_c  = (vec == VMAX);
`endif

    case (state)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d = S_RUN;
          sop_d   = sop_mask;
          pos_d   = pos_mask;
          vec_d   = '0;
          hold_d  = '0;
          ones_d  = '0;
          mm_d    = '0;
          found_d = 1'b0;
          idx_d   = '0;
        end
      end
      S_RUN: begin
        if (hold_cnt == HLAST) begin
          hold_d = '0;
          ones_d = ones_cnt + CW'(f_sop);
          if (mm_c) begin
            mm_d = mismatch_cnt + CW'(1);
            if (!mm_found) begin
              found_d = 1'b1;
              idx_d   = vec;
            end
          end
          if (last_c) state_d = S_DONE;
          else        vec_d   = vec + N'(1);
        end else begin
          hold_d = hold_cnt + HW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; f_sop/f_pos are pre-computed from next vector
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      vec          <= '0;
      hold_cnt     <= '0;
      sop_q        <= '0;
      pos_q        <= '0;
      ones_cnt     <= '0;
      mismatch_cnt <= '0;
      mm_found     <= 1'b0;
      first_mm_idx <= '0;
      busy         <= 1'b0;
      vec_valid    <= 1'b0;
      f_sop        <= 1'b0;
      f_pos        <= 1'b0;
      done         <= 1'b0;
      equiv        <= 1'b1;
    end else begin
      state        <= state_d;
      vec          <= vec_d;
      hold_cnt     <= hold_d;
      sop_q        <= sop_d;
      pos_q        <= pos_d;
      ones_cnt     <= ones_d;
      mismatch_cnt <= mm_d;
      mm_found     <= found_d;
      first_mm_idx <= idx_d;
      busy         <= (state_d == S_RUN);
      vec_valid    <= (state_d == S_RUN);
      f_sop        <= (state_d == S_RUN) ? sop_d[vec_d] : 1'b0;
      f_pos        <= (state_d == S_RUN) ? ~pos_d[vec_d] : 1'b0;
      done         <= (state_d == S_DONE);
      equiv        <= (mm_d == '0) && (state_d != S_RUN);
    end
  end

endmodule

// File: tb/tb_sop_pos_sweep_checker.sv
// Directed bench for sop_pos_sweep_checker: N=3 with HOLD=1 and HOLD=3 instances.
module tb_sop_pos_sweep_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start3;
  logic [7:0] sop_mask, pos_mask;

  logic       busy1, valid1, fs1, fp1, done1, found1, equiv1;
  logic [2:0] vec1, idx1;
  logic [3:0] ones1, mm1;
  logic       busy3, valid3, fs3, fp3, done3, found3, equiv3;
  logic [2:0] vec3, idx3;
  logic [3:0] ones3, mm3;

  int nchecks = 0;
  int nerrors = 0;
  int lat;
  int npulse;
  logic [7:0] m;

  always #5 clk = ~clk;

  sop_pos_sweep_checker #(.N(3), .HOLD(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .sop_mask(sop_mask), .pos_mask(pos_mask),
    .busy(busy1), .vec_valid(valid1), .vec(vec1), .f_sop(fs1), .f_pos(fp1), .done(done1),
    .ones_cnt(ones1), .mismatch_cnt(mm1), .mm_found(found1), .first_mm_idx(idx1), .equiv(equiv1));

  sop_pos_sweep_checker #(.N(3), .HOLD(3)) u3 (
    .clk(clk), .rst(rst), .start(start3), .sop_mask(sop_mask), .pos_mask(pos_mask),
    .busy(busy3), .vec_valid(valid3), .vec(vec3), .f_sop(fs3), .f_pos(fp3), .done(done3),
    .ones_cnt(ones3), .mismatch_cnt(mm3), .mm_found(found3), .first_mm_idx(idx3), .equiv(equiv3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulse start on the selected instance; returns just after the accepting edge
  task automatic go(input bit sel, input logic [7:0] s, input logic [7:0] p);
    sop_mask = s;
    pos_mask = p;
    if (sel) start3 = 1'b1; else start1 = 1'b1;
    tick();
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  // Edges until done is seen, bounded by maxc
  task automatic wait_done(input bit sel, input int maxc, output int n);
    n = 0;
    while (n < maxc) begin
      tick();
      n++;
      if (sel ? done3 : done1) return;
    end
    n = maxc + 1000;
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0; sop_mask = '0; pos_mask = '0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_busy", busy1, 0);
    chk("rst_valid", valid1, 0);
    chk("rst_vec", vec1, 0);
    chk("rst_done", done1, 0);
    chk("rst_ones", ones1, 0);
    chk("rst_mm", mm1, 0);
    chk("rst_found", found1, 0);
    chk("rst_fsop", fs1, 0);
    chk("rst_fpos", fp1, 0);
    chk("rst_equiv", equiv1, 1);

    // 1: equivalent forms of F = y | ~x&z, per-vector outputs
    m = 8'hCE;
    go(0, 8'hCE, 8'h31);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t1_vec%0d", k), vec1, k);
      chk($sformatf("t1_valid%0d", k), valid1, 1);
      chk($sformatf("t1_fsop%0d", k), fs1, m[k]);
      chk($sformatf("t1_fpos%0d", k), fp1, m[k]);
      chk($sformatf("t1_nodone%0d", k), done1, 0);
      tick();
    end
    chk("t1_done", done1, 1);
    chk("t1_valid_off", valid1, 0);
    chk("t1_ones", ones1, 5);
    chk("t1_mm", mm1, 0);
    chk("t1_found", found1, 0);
    chk("t1_equiv", equiv1, 1);
    tick();
    chk("t1_done_pulse", done1, 0);
    chk("t1_ones_hold", ones1, 5);

    // 2: single mismatch at vector 1
    go(0, 8'hCE, 8'h33);
    chk("t2_equiv_busy", equiv1, 0);
    wait_done(0, 40, lat);
`ifdef SWEEP_STOP_ON_MISMATCH_EN
    chk("t2_lat", lat, 2);
    chk("t2_ones", ones1, 1);
`else
    chk("t2_lat", lat, 8);
    chk("t2_ones", ones1, 5);
`endif
    chk("t2_mm", mm1, 1);
    chk("t2_found", found1, 1);
    chk("t2_idx", idx1, 1);
    chk("t2_equiv", equiv1, 0);
    tick();

    // 3: HOLD=3, each vector stable three cycles
    go(1, 8'hCE, 8'h31);
    for (int k = 0; k < 24; k++) begin
      chk($sformatf("t3_vec%0d", k), vec3, k / 3);
      tick();
    end
    chk("t3_done", done3, 1);
    chk("t3_ones", ones3, 5);
    chk("t3_equiv", equiv3, 1);
    tick();

    // 4: restart while busy ignored, mask change after accept ignored
    go(0, 8'hCE, 8'h31);
    lat = 0;
    while (lat < 40) begin
      sop_mask = (lat + 1 >= 2) ? 8'h00 : 8'hCE;
      start1 = (lat + 1 == 4);
      tick();
      lat++;
      if (done1) break;
    end
    start1 = 1'b0;
    chk("t4_lat", lat, 8);
    chk("t4_ones", ones1, 5);
    chk("t4_mm", mm1, 0);
    tick();

    // 5: reset mid-sweep aborts without done
    go(0, 8'hCE, 8'h33);
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy", busy1, 0);
    chk("t5_vec", vec1, 0);
    chk("t5_ones", ones1, 0);
    chk("t5_mm", mm1, 0);
    chk("t5_equiv", equiv1, 1);
    npulse = 0;
    for (int k = 0; k < 12; k++) begin
      if (done1) npulse++;
      tick();
    end
    chk("t5_no_done", npulse, 0);

    // 5b: back-to-back start in the done cycle
    go(0, 8'hCE, 8'h31);
    wait_done(0, 40, lat);
    chk("t5b_lat1", lat, 8);
    go(0, 8'hCE, 8'h33);
    chk("t5b_busy", busy1, 1);
    chk("t5b_vec", vec1, 0);
    chk("t5b_ones_clr", ones1, 0);
    chk("t5b_done_off", done1, 0);
    wait_done(0, 40, lat);
`ifdef SWEEP_STOP_ON_MISMATCH_EN
    chk("t5b_lat2", lat, 2);
`else
    chk("t5b_lat2", lat, 8);
`endif
    chk("t5b_idx", idx1, 1);
    tick();

    // 6: every vector mismatches
    go(0, 8'h00, 8'h00);
    wait_done(0, 40, lat);
    chk("t6_ones", ones1, 0);
`ifdef SWEEP_STOP_ON_MISMATCH_EN
    chk("t6_lat", lat, 1);
    chk("t6_mm", mm1, 1);
`else
    chk("t6_lat", lat, 8);
    chk("t6_mm", mm1, 8);
`endif
    chk("t6_idx", idx1, 0);
    chk("t6_found", found1, 1);
    chk("t6_equiv", equiv1, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
